// File: rtl/pgm_pkg.sv
// Shared constants and types for the packet-generator write side: beat flags,
// config beat layout, config type codes, register indices and data-path states.
package pgm_pkg;

  localparam int PHV_W  = 1024;
  localparam int BEAT_W = 134;
  localparam int RAM_W  = 144;

  localparam int FLAG_HI = 133;
  localparam int FLAG_LO = 132;
  localparam logic [1:0] FLAG_HEAD = 2'b01;
  localparam logic [1:0] FLAG_BODY = 2'b11;
  localparam logic [1:0] FLAG_TAIL = 2'b10;

  localparam int PGM_TAG_HI = 111;
  localparam int PGM_TAG_LO = 109;
  localparam logic [2:0] PGM_TAG = 3'b111;

  localparam logic [2:0]  CFG_TYPE_WR      = 3'b010;
  localparam logic [2:0]  CFG_TYPE_RD      = 3'b001;
  localparam logic [2:0]  CFG_TYPE_RD_RESP = 3'b011;
  localparam logic [15:0] CFG_ADDR_SPACE   = 16'h0001;

  localparam int NUM_CFG_REGS = 4;
  localparam int REG_IDX_W    = 2;
  localparam int REG_PGM_CNT  = 1;
  localparam int REG_PGM_CTRL = 2;

  // Field order matches the config ring beat, MSB first.
  typedef struct packed {
    logic [5:0]  flags;
    logic        valid;
    logic [2:0]  cfg_type;
    logic [11:0] rsvd;
    logic [7:0]  dst;
    logic [7:0]  src;
    logic [31:0] addr;
    logic [31:0] mask;
    logic [31:0] data;
  } cfg_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BYPASS = 2'd1,
    ST_STORE  = 2'd2
  } wr_state_e;

  function automatic logic [1:0] beat_flag(input logic [BEAT_W-1:0] beat);
    return beat[FLAG_HI:FLAG_LO];
  endfunction

endpackage

// File: rtl/pgm_wr_ctrl_if.sv
// Config ring seen by pgm_wr_ctrl: beats in from the DMA side, beats out to the
// next module, and the ready that is passed straight back upstream.
interface pgm_wr_ctrl_if;
  import pgm_pkg::*;

  logic [BEAT_W-1:0] cin_wr_data;
  logic              cin_wr_data_wr;
  logic              cin_wr_ready;
  logic [BEAT_W-1:0] cout_wr_data;
  logic              cout_wr_data_wr;
  logic              cout_wr_ready;

  modport master (
    output cin_wr_data, cin_wr_data_wr, cin_wr_ready,
    input  cout_wr_data, cout_wr_data_wr, cout_wr_ready
  );

  modport slave (
    input  cin_wr_data, cin_wr_data_wr, cin_wr_ready,
    output cout_wr_data, cout_wr_data_wr, cout_wr_ready
  );
endinterface

// File: rtl/pgm_wr_cfg.sv
// Config ring stage: decodes writes into local registers and forwards every beat
// one cycle later. Define PGM_WR_CFG_RD_EN to answer reads in the forwarded beat.
module pgm_wr_cfg
  import pgm_pkg::*;
#(
  parameter logic [7:0] MODULE_ID = 8'd70
) (
  input  logic         clk,
  input  logic         rst_n,
  pgm_wr_ctrl_if.slave cfg
);

  localparam logic [7:0] REG_LIMIT = 8'(NUM_CFG_REGS);

  cfg_beat_t   beat_in;
  cfg_beat_t   beat_out;
  logic        hit;
  logic        wr_hit;
  logic [7:0]  reg_idx;
  logic [31:0] cfg_regs [NUM_CFG_REGS];

  assign beat_in = cfg_beat_t'(cfg.cin_wr_data);
  assign reg_idx = beat_in.addr[7:0];
  assign hit     = cfg.cin_wr_data_wr && (beat_in.dst == MODULE_ID);
  assign wr_hit  = hit && (beat_in.cfg_type == CFG_TYPE_WR)
                       && (beat_in.addr[31:16] == CFG_ADDR_SPACE)
                       && (reg_idx < REG_LIMIT);

  assign cfg.cout_wr_ready = cfg.cin_wr_ready;

  // reg1 is PGM_CNT, reg2 is PGM_CTRL (bit0 = enable); others are spare.
  // NOTE: the register array is tiny and software expects known values, so it is
  // reset explicitly; a large RAM-style array would be left unreset instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CFG_REGS; i++) cfg_regs[i] <= '0;
    end else if (wr_hit) begin
      // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
      cfg_regs[reg_idx[REG_IDX_W-1:0]] <=
        (cfg_regs[reg_idx[REG_IDX_W-1:0]] & ~beat_in.mask) | (beat_in.data & beat_in.mask);
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns beat_out and no latch is inferred.
    beat_out = beat_in;
`ifdef PGM_WR_CFG_RD_EN
    if (hit && (beat_in.cfg_type == CFG_TYPE_RD)) begin
      beat_out.cfg_type = CFG_TYPE_RD_RESP;
      beat_out.data     = (reg_idx < REG_LIMIT) ? cfg_regs[reg_idx[REG_IDX_W-1:0]] : 32'h0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg.cout_wr_data_wr <= 1'b0;
      cfg.cout_wr_data    <= '0;
    end else begin
      cfg.cout_wr_data_wr <= cfg.cin_wr_data_wr;
      cfg.cout_wr_data    <= beat_out;
    end
  end

endmodule

// File: rtl/pgm_wr_ctrl.sv
// PGM write side: stores "program" packets into PGM RAM and bypasses all others
// to pgm_rd with one cycle of latency. Optional read-back: PGM_WR_CFG_RD_EN.
module pgm_wr_ctrl
  import pgm_pkg::*;
#(
  parameter logic [7:0] MODULE_ID = 8'd70,
  parameter int         RAM_DEPTH = 128,
  localparam int        ADDR_W    = $clog2(RAM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PHV_W-1:0]  in_wr_phv,
  input  logic              in_wr_phv_wr,
  output logic              out_wr_phv_alf,
  input  logic [BEAT_W-1:0] in_wr_data,
  input  logic              in_wr_data_wr,
  input  logic              in_wr_valid,
  input  logic              in_wr_valid_wr,
  output logic              out_wr_alf,
  output logic [PHV_W-1:0]  out_wr_phv,
  output logic              out_wr_phv_wr,
  input  logic              in_wr_phv_alf,
  output logic [BEAT_W-1:0] out_wr_data,
  output logic              out_wr_data_wr,
  output logic              out_wr_valid,
  output logic              out_wr_valid_wr,
  input  logic              in_wr_alf,
  output logic              wr2ram_wr_en,
  output logic [RAM_W-1:0]  wr2ram_wdata,
  output logic [ADDR_W-1:0] wr2ram_addr,
  output logic              pgm_bypass_flag,
  output logic              pgm_sent_start_flag,
  output logic              pgm_sent_finish_flag,
  pgm_wr_ctrl_if.slave      cfg
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(RAM_DEPTH);

  wr_state_e       state;
  wr_state_e       state_next;
  logic [ADDR_W:0] wr_idx;
  logic            is_head;
  logic            is_tail;
  logic            is_pgm;
  logic            pass_cycle;
  logic            store_cycle;

  assign is_head = in_wr_data_wr && (beat_flag(in_wr_data) == FLAG_HEAD);
  assign is_tail = in_wr_data_wr && (beat_flag(in_wr_data) == FLAG_TAIL);
  assign is_pgm  = (in_wr_data[PGM_TAG_HI:PGM_TAG_LO] == PGM_TAG);

  assign out_wr_phv_alf = in_wr_phv_alf;
  assign out_wr_alf     = in_wr_alf;

  pgm_wr_cfg #(.MODULE_ID(MODULE_ID)) u_cfg (
    .clk   (clk),
    .rst_n (rst_n),
    .cfg   (cfg)
  );

  // A head beat always wins: it decides the mode of its own cycle, aborting any
  // packet in flight, so the head is already bypassed or stored on arrival.
  always_comb begin
    state_next  = state;
    pass_cycle  = 1'b0;
    store_cycle = 1'b0;
    if (is_head) begin
      state_next  = is_pgm ? ST_STORE : ST_BYPASS;
      pass_cycle  = !is_pgm;
      store_cycle = is_pgm;
    end else begin
      pass_cycle  = (state == ST_BYPASS);
      store_cycle = (state == ST_STORE);
      if (in_wr_valid_wr || ((state == ST_STORE) && is_tail)) state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Bypass path: everything is registered once, and the flag lines up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_wr_phv      <= '0;
      out_wr_phv_wr   <= 1'b0;
      out_wr_data     <= '0;
      out_wr_data_wr  <= 1'b0;
      out_wr_valid    <= 1'b0;
      out_wr_valid_wr <= 1'b0;
      pgm_bypass_flag <= 1'b0;
    end else begin
      out_wr_phv      <= (pass_cycle && in_wr_phv_wr) ? in_wr_phv : '0;
      out_wr_phv_wr   <= pass_cycle && in_wr_phv_wr;
      out_wr_data     <= (pass_cycle && in_wr_data_wr) ? in_wr_data : '0;
      out_wr_data_wr  <= pass_cycle && in_wr_data_wr;
      out_wr_valid    <= pass_cycle && in_wr_valid_wr && in_wr_valid;
      out_wr_valid_wr <= pass_cycle && in_wr_valid_wr;
      pgm_bypass_flag <= pass_cycle;
    end
  end

  // Store path: wr_idx is the next free entry; once it reaches DEPTH further
  // beats are dropped and wr2ram_addr simply keeps the last written address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx               <= '0;
      wr2ram_wr_en         <= 1'b0;
      wr2ram_wdata         <= '0;
      wr2ram_addr          <= '0;
      pgm_sent_start_flag  <= 1'b0;
      pgm_sent_finish_flag <= 1'b0;
    end else begin
      wr2ram_wr_en         <= 1'b0;
      pgm_sent_start_flag  <= 1'b0;
      pgm_sent_finish_flag <= 1'b0;
      if (store_cycle && in_wr_data_wr) begin
        pgm_sent_finish_flag <= is_tail;
        if (is_head) begin
          wr2ram_wr_en        <= 1'b1;
          wr2ram_addr         <= '0;
          wr2ram_wdata        <= {{(RAM_W-BEAT_W){1'b0}}, in_wr_data};
          wr_idx              <= (ADDR_W+1)'(1);
          pgm_sent_start_flag <= 1'b1;
        end else if (wr_idx < DEPTH) begin
          wr2ram_wr_en <= 1'b1;
          wr2ram_addr  <= wr_idx[ADDR_W-1:0];
          wr2ram_wdata <= {{(RAM_W-BEAT_W){1'b0}}, in_wr_data};
          wr_idx       <= wr_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pgm_wr_ctrl.sv
// Directed self-checking bench for pgm_wr_ctrl: config ring, program storage,
// bypass, overflow saturation, stray beats, head abort and asynchronous reset.
module tb_pgm_wr_ctrl;
  import pgm_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [PHV_W-1:0]  in_wr_phv;
  logic              in_wr_phv_wr;
  logic              out_wr_phv_alf;
  logic [BEAT_W-1:0] in_wr_data;
  logic              in_wr_data_wr;
  logic              in_wr_valid;
  logic              in_wr_valid_wr;
  logic              out_wr_alf;
  logic [PHV_W-1:0]  out_wr_phv;
  logic              out_wr_phv_wr;
  logic              in_wr_phv_alf;
  logic [BEAT_W-1:0] out_wr_data;
  logic              out_wr_data_wr;
  logic              out_wr_valid;
  logic              out_wr_valid_wr;
  logic              in_wr_alf;
  logic              wr2ram_wr_en;
  logic [RAM_W-1:0]  wr2ram_wdata;
  logic [6:0]        wr2ram_addr;
  logic              pgm_bypass_flag;
  logic              pgm_sent_start_flag;
  logic              pgm_sent_finish_flag;

  pgm_wr_ctrl_if cfg_if ();

  pgm_wr_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_wr_phv(in_wr_phv), .in_wr_phv_wr(in_wr_phv_wr), .out_wr_phv_alf(out_wr_phv_alf),
    .in_wr_data(in_wr_data), .in_wr_data_wr(in_wr_data_wr),
    .in_wr_valid(in_wr_valid), .in_wr_valid_wr(in_wr_valid_wr), .out_wr_alf(out_wr_alf),
    .out_wr_phv(out_wr_phv), .out_wr_phv_wr(out_wr_phv_wr), .in_wr_phv_alf(in_wr_phv_alf),
    .out_wr_data(out_wr_data), .out_wr_data_wr(out_wr_data_wr),
    .out_wr_valid(out_wr_valid), .out_wr_valid_wr(out_wr_valid_wr), .in_wr_alf(in_wr_alf),
    .wr2ram_wr_en(wr2ram_wr_en), .wr2ram_wdata(wr2ram_wdata), .wr2ram_addr(wr2ram_addr),
    .pgm_bypass_flag(pgm_bypass_flag), .pgm_sent_start_flag(pgm_sent_start_flag),
    .pgm_sent_finish_flag(pgm_sent_finish_flag), .cfg(cfg_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_wr_phv_wr   = 1'b0;
    in_wr_data     = '0;
    in_wr_data_wr  = 1'b0;
    in_wr_valid    = 1'b0;
    in_wr_valid_wr = 1'b0;
    cfg_if.cin_wr_data    = '0;
    cfg_if.cin_wr_data_wr = 1'b0;
  endtask

  task automatic drive_beat(input logic [BEAT_W-1:0] b);
    clear_inputs();
    in_wr_data    = b;
    in_wr_data_wr = 1'b1;
  endtask

  function automatic logic [BEAT_W-1:0] mk_beat(input logic [1:0] flg, input logic [2:0] tag,
                                                input logic [15:0] seq);
    logic [BEAT_W-1:0] b;
    b          = '0;
    b[133:132] = flg;
    b[111:109] = tag;
    b[47:32]   = ~seq;
    b[15:0]    = seq;
    return b;
  endfunction

  function automatic logic [BEAT_W-1:0] mk_cfg(input logic [2:0] typ, input logic [7:0] dst,
                                               input logic [31:0] addr, input logic [31:0] mask,
                                               input logic [31:0] data);
    return {6'b010000, 1'b1, typ, 12'h000, dst, 8'd61, addr, mask, data};
  endfunction

  logic [BEAT_W-1:0] pk [4];
  logic [BEAT_W-1:0] cbeat;
  logic [BEAT_W-1:0] rexp;
  logic [PHV_W-1:0]  phv_b;
  int                fin_cnt;

  initial begin
    rst_n         = 1'b0;
    in_wr_phv     = '0;
    in_wr_phv_alf = 1'b0;
    in_wr_alf     = 1'b0;
    cfg_if.cin_wr_ready = 1'b0;
    clear_inputs();
    for (int w = 0; w < 32; w++) phv_b[w*32 +: 32] = 32'hB000_0000 + 32'(w);

    // Reset state
    tick(); tick();
    check("rst_wr_en",    144'(wr2ram_wr_en), 144'(0));
    check("rst_addr",     144'(wr2ram_addr), 144'(0));
    check("rst_data_wr",  144'(out_wr_data_wr), 144'(0));
    check("rst_bypass",   144'(pgm_bypass_flag), 144'(0));
    check("rst_cout_wr",  144'(cfg_if.cout_wr_data_wr), 144'(0));
    check("rst_state",    144'(dut.state), 144'(ST_IDLE));
    rst_n = 1'b1;
    tick();

    // Almost-full mirrors
    in_wr_phv_alf = 1'b1; #1;
    check("phv_alf_hi", 144'(out_wr_phv_alf), 144'(1));
    in_wr_alf = 1'b1; #1;
    check("alf_hi", 144'(out_wr_alf), 144'(1));
    in_wr_phv_alf = 1'b0; in_wr_alf = 1'b0; #1;
    check("alf_lo", 144'({out_wr_phv_alf, out_wr_alf}), 144'(0));

    // Config writes: full write, masked write, foreign destination, PGM_CTRL
    cbeat = mk_cfg(CFG_TYPE_WR, 8'd70, 32'h0001_0001, 32'hffff_ffff, 32'h0000_4000);
    cfg_if.cin_wr_data = cbeat; cfg_if.cin_wr_data_wr = 1'b1;
    tick();
    check("cfg_fwd_wr",   144'(cfg_if.cout_wr_data_wr), 144'(1));
    check("cfg_fwd_data", 144'(cfg_if.cout_wr_data), 144'(cbeat));
    check("cfg_reg1",     144'(dut.u_cfg.cfg_regs[1]), 144'(32'h4000));
    cbeat = mk_cfg(CFG_TYPE_WR, 8'd70, 32'h0001_0001, 32'h0000_ffff, 32'h1234_5678);
    cfg_if.cin_wr_data = cbeat;
    tick();
    check("cfg_reg1_mask", 144'(dut.u_cfg.cfg_regs[1]), 144'(32'h5678));
    cbeat = mk_cfg(CFG_TYPE_WR, 8'd71, 32'h0001_0001, 32'hffff_ffff, 32'hffff_ffff);
    cfg_if.cin_wr_data = cbeat;
    tick();
    check("cfg_other_dst", 144'(dut.u_cfg.cfg_regs[1]), 144'(32'h5678));
    check("cfg_other_fwd", 144'(cfg_if.cout_wr_data), 144'(cbeat));
    cfg_if.cin_wr_data = mk_cfg(CFG_TYPE_WR, 8'd70, 32'h0001_0002, 32'h0000_00ff, 32'h0000_0003);
    tick();
    check("cfg_reg2_set", 144'(dut.u_cfg.cfg_regs[2]), 144'(3));
    cfg_if.cin_wr_data = mk_cfg(CFG_TYPE_WR, 8'd70, 32'h0001_0002, 32'hffff_ffff, 32'h0);
    tick();
    check("cfg_reg2_clr", 144'(dut.u_cfg.cfg_regs[2]), 144'(0));
    cbeat = mk_cfg(CFG_TYPE_RD, 8'd70, 32'h0001_0001, 32'h0, 32'h0);
    cfg_if.cin_wr_data = cbeat;
`ifdef PGM_WR_CFG_RD_EN
    rexp = mk_cfg(CFG_TYPE_RD_RESP, 8'd70, 32'h0001_0001, 32'h0, 32'h5678);
`else
    rexp = cbeat;
`endif
    tick();
    check("cfg_read_fwd", 144'(cfg_if.cout_wr_data), 144'(rexp));
    clear_inputs();
    tick();
    check("cfg_fwd_idle", 144'(cfg_if.cout_wr_data_wr), 144'(0));
    cfg_if.cin_wr_ready = 1'b1; #1;
    check("ready_hi", 144'(cfg_if.cout_wr_ready), 144'(1));
    cfg_if.cin_wr_ready = 1'b0; #1;
    check("ready_lo", 144'(cfg_if.cout_wr_ready), 144'(0));

    // Program packet: head, two bodies, tail, then its valid
    pk[0] = mk_beat(FLAG_HEAD, 3'b111, 16'h0100);
    pk[1] = mk_beat(FLAG_BODY, 3'b000, 16'h0101);
    pk[2] = mk_beat(FLAG_BODY, 3'b000, 16'h0102);
    pk[3] = mk_beat(FLAG_TAIL, 3'b000, 16'h0103);
    for (int i = 0; i < 4; i++) begin
      drive_beat(pk[i]);
      in_wr_phv = phv_b; in_wr_phv_wr = (i == 0);
      tick();
      check("pgm_wr_en",  144'(wr2ram_wr_en), 144'(1));
      check("pgm_addr",   144'(wr2ram_addr), 144'(i));
      check("pgm_wdata",  144'(wr2ram_wdata), {10'b0, pk[i]});
      check("pgm_start",  144'(pgm_sent_start_flag), 144'(i == 0));
      check("pgm_finish", 144'(pgm_sent_finish_flag), 144'(i == 3));
      check("pgm_out_idle", 144'({out_wr_data_wr, out_wr_phv_wr, pgm_bypass_flag}), 144'(0));
    end
    clear_inputs(); in_wr_valid = 1'b1; in_wr_valid_wr = 1'b1;
    tick();
    check("pgm_valid_eaten", 144'({out_wr_valid_wr, wr2ram_wr_en, pgm_sent_finish_flag}), 144'(0));

    // Bypass packet: identical beats and PHV one cycle later
    pk[0] = mk_beat(FLAG_HEAD, 3'b011, 16'h0200);
    pk[1] = mk_beat(FLAG_BODY, 3'b111, 16'h0201);
    pk[2] = mk_beat(FLAG_BODY, 3'b000, 16'h0202);
    pk[3] = mk_beat(FLAG_TAIL, 3'b000, 16'h0203);
    for (int i = 0; i < 4; i++) begin
      drive_beat(pk[i]);
      in_wr_phv = phv_b; in_wr_phv_wr = (i == 0);
      tick();
      check("bp_data_wr", 144'(out_wr_data_wr), 144'(1));
      check("bp_data",    144'(out_wr_data), 144'(pk[i]));
      check("bp_flag",    144'(pgm_bypass_flag), 144'(1));
      check("bp_no_ram",  144'(wr2ram_wr_en), 144'(0));
      check("bp_phv_wr",  144'(out_wr_phv_wr), 144'(i == 0));
      if (i == 0) check("bp_phv", 144'(out_wr_phv == phv_b), 144'(1));
    end
    clear_inputs(); in_wr_valid = 1'b1; in_wr_valid_wr = 1'b1;
    tick();
    check("bp_valid", 144'({out_wr_valid_wr, out_wr_valid, pgm_bypass_flag, out_wr_data_wr}),
          144'(4'b1110));
    clear_inputs();
    tick();
    check("bp_done", 144'({out_wr_valid_wr, pgm_bypass_flag}), 144'(0));

    // Stray body in IDLE is dropped
    drive_beat(mk_beat(FLAG_BODY, 3'b111, 16'h0300));
    tick();
    check("stray_body", 144'({wr2ram_wr_en, out_wr_data_wr, pgm_bypass_flag}), 144'(0));

    // Head mid-packet aborts a bypass packet and starts storage
    drive_beat(mk_beat(FLAG_HEAD, 3'b000, 16'h0400));
    tick();
    check("abort_bp_head", 144'(out_wr_data_wr), 144'(1));
    drive_beat(mk_beat(FLAG_HEAD, 3'b111, 16'h0401));
    tick();
    check("abort_store", 144'({wr2ram_wr_en, pgm_sent_start_flag, out_wr_data_wr, pgm_bypass_flag}),
          144'(4'b1100));
    check("abort_addr", 144'(wr2ram_addr), 144'(0));
    drive_beat(mk_beat(FLAG_TAIL, 3'b000, 16'h0402));
    tick();
    check("abort_tail", 144'({wr2ram_wr_en, pgm_sent_finish_flag, wr2ram_addr}), {142'b0, 2'b11} << 7 | 144'(1));

    // Overflow: 130-beat program packet saturates at address 127
    fin_cnt = 0;
    for (int i = 0; i < 130; i++) begin
      drive_beat(mk_beat((i == 0) ? FLAG_HEAD : ((i == 129) ? FLAG_TAIL : FLAG_BODY),
                         (i == 0) ? 3'b111 : 3'b000, 16'(i)));
      tick();
      check("ovf_wr_en", 144'(wr2ram_wr_en), 144'(i < 128));
      check("ovf_addr",  144'(wr2ram_addr), 144'((i < 128) ? i : 127));
      if (pgm_sent_finish_flag) fin_cnt++;
    end
    check("ovf_finish_last", 144'(pgm_sent_finish_flag), 144'(1));
    check("ovf_finish_cnt",  144'(fin_cnt), 144'(1));
    clear_inputs();
    tick();

    // Asynchronous reset in the middle of a program packet
    drive_beat(mk_beat(FLAG_HEAD, 3'b111, 16'h0500));
    tick();
    drive_beat(mk_beat(FLAG_BODY, 3'b000, 16'h0501));
    tick();
    check("mid_addr_pre", 144'(wr2ram_addr), 144'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", 144'(dut.state), 144'(ST_IDLE));
    check("mid_rst_addr",  144'(wr2ram_addr), 144'(0));
    check("mid_rst_outs",  144'({wr2ram_wr_en, pgm_sent_start_flag, pgm_sent_finish_flag,
                                 out_wr_data_wr, pgm_bypass_flag}), 144'(0));
    clear_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    drive_beat(mk_beat(FLAG_BODY, 3'b000, 16'h0502));
    tick();
    check("post_rst_body", 144'(wr2ram_wr_en), 144'(0));
    clear_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
